// File: rtl/cnt_pkg.sv
// Shared constants for the step/limit counter family.
// Mode and direction encodings used by cntn_mod.
package cnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/cnt_pre.sv
// Enable prescaler: divides en ticks by pre+1.
// adv is combinational so the counter moves on the same edge.
module cnt_pre #(
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] pre,
  output logic                 adv
);

  localparam logic [PRE_WIDTH-1:0] ONE = {{(PRE_WIDTH-1){1'b0}}, 1'b1};

  logic [PRE_WIDTH-1:0] pcnt;

  assign adv = en && (pcnt == pre);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= adv ? '0 : pcnt + ONE;
    end
  end

endmodule

// File: rtl/cntn_mod.sv
// Modulo up/down counter with wrap/saturate, prescaler,
// terminal-count pulse and sticky overflow flag.
module cntn_mod
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     step,
  input  logic [WIDTH-1:0]     lim,
  input  logic [PRE_WIDTH-1:0] pre,
  input  logic                 load,
  input  logic [WIDTH-1:0]     cin,
  input  logic                 clr_ovf,
  output logic [WIDTH-1:0]     cnt,
  output logic                 tc,
  output logic                 ovf
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic             adv;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   lim_x;
  logic [WIDTH:0]   s_up;
  logic [WIDTH:0]   s_up_wr;
  logic [WIDTH:0]   s_dn_wr;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_d;
  logic             ovf_d;

  cnt_pre #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_pre (
    .clk (clk),
    .nrst(nrst),
    .en  (en),
    .clr (load),
    .pre (pre),
    .adv (adv)
  );

  assign cnt_x   = {1'b0, cnt};
  assign step_x  = {1'b0, step};
  assign lim_x   = {1'b0, lim};
  assign s_up    = cnt_x + step_x;
  assign s_up_wr = s_up - lim_x - ONE;
  assign s_dn_wr = cnt_x + lim_x + ONE - step_x;

  always_comb begin
    cnt_d = cnt;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = (cin > lim) ? lim : cin;
    end else if (adv && (step != '0)) begin
      if (dir == DIR_UP) begin
        if (s_up <= lim_x) begin
          cnt_d = s_up[WIDTH-1:0];
        end else begin
          tc_d  = 1'b1;
          cnt_d = (mode == MODE_SAT) ? lim : s_up_wr[WIDTH-1:0];
        end
      end else begin
        if (step <= cnt) begin
          cnt_d = cnt - step;
        end else begin
          tc_d  = 1'b1;
          cnt_d = (mode == MODE_SAT) ? '0 : s_dn_wr[WIDTH-1:0];
        end
      end
    end
  end

  // set beats clear on the same edge
  assign ovf_d = tc_d | (ovf & ~clr_ovf);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_d;
      tc  <= tc_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: doc/cntn_mod.md
Name: cntn_mod

Overview:
Parametrised successor to the basic step/load counter. Adds a programmable modulo limit, up/down direction, wrap or saturate mode, an enable prescaler, a terminal-count pulse and a sticky overflow flag. It serves as the sample-address and timebase counter in the CPLD acquisition path, where the limit is the buffer depth and the prescaler is the timebase divider.

Parameters:
WIDTH, 8, counter, step, load-value and limit width
PRE_WIDTH, 4, prescaler width; division ratio is pre+1, range 1..2^PRE_WIDTH

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
en  input  1  1 = count-enable tick
dir  input  1  0 = up, 1 = down
mode  input  1  0 = wrap (modulo lim+1), 1 = saturate
step  input  WIDTH  increment/decrement applied per advance
lim  input  WIDTH  inclusive upper bound of the count range 0..lim
pre  input  PRE_WIDTH  prescaler divisor minus one
load  input  1  synchronous load strobe
cin  input  WIDTH  load value
clr_ovf  input  1  clears the sticky overflow flag
cnt  output  WIDTH  current count, registered
tc  output  1  one-cycle terminal-count pulse, registered
ovf  output  1  sticky overflow flag, registered

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (nrst). While nrst=0: cnt=0, tc=0, ovf=0, prescaler count pcnt=0.
- Priority per edge: load > en. Reset overrides everything, including mid-operation.
- Load:
  - cnt <= cin when cin<=lim; otherwise cnt <= lim (clamped).
  - pcnt <= 0; tc <= 0; ovf is unchanged.
- Prescaler: on each edge with en=1 and load=0:
  - if pcnt==pre, then pcnt <= 0 and an "advance" occurs this edge;
  - else pcnt <= pcnt+1 and there is no advance.
  - pre=0 gives an advance on every enabled cycle. When en=0, pcnt holds.
- Advance, up (dir=0): compute s = cnt + step in WIDTH+1 bits.
  - s <= lim: cnt <= s, tc <= 0.
  - s > lim, wrap: cnt <= s - (lim+1), truncated to WIDTH. This is a single subtraction; with step > lim+1 the result is not guaranteed to lie in 0..lim.
  - s > lim, saturate: cnt <= lim.
  - In both overflow cases tc <= 1.
- Advance, down (dir=1):
  - step <= cnt: cnt <= cnt - step, tc <= 0.
  - step > cnt, wrap: cnt <= cnt + lim + 1 - step, computed in WIDTH+1 bits.
  - step > cnt, saturate: cnt <= 0.
  - In both underflow cases tc <= 1.
- Saturated hold: while saturated at lim (up) or 0 (down), every further advance with step>0 re-asserts tc. tc is high for each such cycle, not once only.
- step=0: an advance leaves cnt unchanged and tc=0.
- Latency:
  - tc is high in exactly the cycle in which cnt first shows the wrapped or clamped value; otherwise tc=0.
  - Non-advance cycles drive tc=0.
- ovf: set by any edge that sets tc. Cleared by clr_ovf. If set and clear occur on the same edge, set wins.
- Runtime lim change below the current cnt: the next up-advance takes the overflow path (s > lim). The next down-advance uses the normal subtraction path. No immediate correction is made.
- dir, mode, lim and step may change on any cycle. Each edge uses the values sampled at that edge.
- lim = 2^WIDTH - 1 reproduces plain modular counting with tc on carry/borrow.

Decomposition:
- Shared package cnt_pkg: mode constants (MODE_WRAP=0, MODE_SAT=1) and direction constants (DIR_UP=0, DIR_DN=1).
- One sub-module, cnt_pre: the prescaler. Inputs clk, nrst, en, clr (driven by load), pre. Output adv, combinational, asserted when en && pcnt==pre.
- The arithmetic and limit compare stay in cntn_mod.

Test Plan:
- Reset mid-count: WIDTH=8, cnt=0x37, drop nrst asynchronously between edges -> cnt=0, tc=0, ovf=0 immediately, without waiting for a clock edge.
- Wrap up: lim=9, step=3, pre=0, mode=0, en=1 from cnt=0 -> sequence 3,6,9,2,5; tc high only in the cycle showing 2; ovf=1 from then on.
- Saturate down: lim=100, load cin=5, dir=1, mode=1, step=2 -> 3,1,0,0; tc high in both cycles showing 0; clr_ovf together with a further saturating advance -> ovf remains 1.
- Prescaler: pre=3, step=1, lim=255, en held high -> cnt increments every 4th clock. Pulse load cin=200 mid-period -> cnt=200, next increment 4 enabled cycles later.
- Load clamp and priority: lim=50, load=1 with cin=80 and en=1 -> cnt=50, tc=0. Then wrap up with step=1 -> cnt=0 and tc=1 on the next advance.
- Full-range carry: lim=255, cnt=254, step=4, mode=0 -> cnt=2, tc=1. Then dir=1, step=3 -> cnt=255, tc=1.
